// File: rtl/seg7_mux_display.sv
// N-digit multiplexed common-anode 7-segment driver: sequential double-dabble conversion,
// built-in scan prescaler, leading-zero blanking and overflow dashes. Optional decimal points: SEG7_DP_EN.
module seg7_mux_display #(
    parameter int NUM_DIGITS  = 4,
    parameter int DATA_WIDTH  = 14,
    parameter int REFRESH_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] value,
    input  logic                  load,
    output logic                  busy,
    output logic                  overflow,
    output logic [6:0]            seg7,
    output logic [NUM_DIGITS-1:0] select
`ifdef SEG7_DP_EN
    ,
    input  logic [NUM_DIGITS-1:0] dp_in,
    output logic                  dp
`endif
);

    // Decimal digits needed for the full binary range (log10(2) ~ 0.30103), never fewer than shown.
    localparam int BCD_CALC   = (DATA_WIDTH * 30103) / 100000 + 1;
    localparam int BCD_DIGITS = (BCD_CALC > NUM_DIGITS) ? BCD_CALC : NUM_DIGITS;
    localparam int BCD_W      = BCD_DIGITS * 4;
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int CNT_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [63:0] OVF_LIMIT = 64'(10 ** NUM_DIGITS);

    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    state_t                       state_q, state_d;
    logic [DATA_WIDTH-1:0]        bin_q, bin_d;
    logic [BCD_W-1:0]             bcd_q, bcd_d;
    logic [CNT_W-1:0]             bit_cnt_q, bit_cnt_d;
    logic                         ovf_pend_q, ovf_pend_d;
    logic [NUM_DIGITS-1:0][3:0]   disp_digit_q, disp_digit_d;
    logic                         disp_ovf_q, disp_ovf_d;
    logic [PRE_W-1:0]             prescaler_q, prescaler_d;
    logic [IDX_W-1:0]             scan_idx_q, scan_idx_d;
    logic [NUM_DIGITS-1:0]        select_q, select_d;
    logic [6:0]                   seg7_q, seg7_d;

    logic                         capture;
    logic                         shift_en;
    logic                         commit;
    logic                         tick;
    logic [63:0]                  value_ext;
    logic [BCD_W-1:0]             bcd_adj;
    logic [NUM_DIGITS-1:0]        digit_blank;

    assign value_ext = 64'(value);

    // ---------------- conversion FSM: state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- conversion FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (load) state_d = ST_SHIFT;
            ST_SHIFT: if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ---------------- conversion FSM: outputs ----------------
    always_comb begin
        busy     = (state_q != ST_IDLE);
        capture  = (state_q == ST_IDLE) && load;
        shift_en = (state_q == ST_SHIFT);
        commit   = (state_q == ST_DONE);
    end

    // Add-3 correction applied to every BCD nibble before each shift.
    genvar gi;
    generate
        for (gi = 0; gi < BCD_DIGITS; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                        (bcd_q[gi*4 +: 4] + 4'd3) : bcd_q[gi*4 +: 4];
        end
    endgenerate

    always_comb begin
        bin_d        = bin_q;
        bcd_d        = bcd_q;
        bit_cnt_d    = bit_cnt_q;
        ovf_pend_d   = ovf_pend_q;
        disp_digit_d = disp_digit_q;
        disp_ovf_d   = disp_ovf_q;
        if (capture) begin
            bin_d      = value;
            bcd_d      = '0;
            bit_cnt_d  = '0;
            ovf_pend_d = (value_ext >= OVF_LIMIT);
        end else if (shift_en) begin
            bcd_d     = {bcd_adj[BCD_W-2:0], bin_q[DATA_WIDTH-1]};
            bin_d     = bin_q << 1;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
        // Upper BCD digits beyond the display are dropped; overflow covers them.
        if (commit) begin
            disp_digit_d = bcd_q[NUM_DIGITS*4-1:0];
            disp_ovf_d   = ovf_pend_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bin_q        <= '0;
            bcd_q        <= '0;
            bit_cnt_q    <= '0;
            ovf_pend_q   <= 1'b0;
            disp_digit_q <= '0;
            disp_ovf_q   <= 1'b0;
        end else begin
            bin_q        <= bin_d;
            bcd_q        <= bcd_d;
            bit_cnt_q    <= bit_cnt_d;
            ovf_pend_q   <= ovf_pend_d;
            disp_digit_q <= disp_digit_d;
            disp_ovf_q   <= disp_ovf_d;
        end
    end

    // A digit is blanked when it and every digit above it are zero; digit 0 always shows.
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_blank
            if (gi == 0) begin : g_lsd
                assign digit_blank[gi] = 1'b0;
            end else begin : g_upper
                assign digit_blank[gi] = (disp_digit_q[NUM_DIGITS-1:gi] == '0);
            end
        end
    endgenerate

    // ---------------- scan prescaler and registered digit drive ----------------
    always_comb begin
        tick        = (prescaler_q == PRE_W'(REFRESH_DIV - 1));
        prescaler_d = tick ? '0 : (prescaler_q + PRE_W'(1));
        scan_idx_d  = scan_idx_q;
        if (tick) begin
            scan_idx_d = (scan_idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : (scan_idx_q + IDX_W'(1));
        end
        select_d = ~(NUM_DIGITS'(1) << scan_idx_q);
        if (disp_ovf_q) begin
            seg7_d = SEG_DASH;
        end else if (digit_blank[scan_idx_q]) begin
            seg7_d = SEG_BLANK;
        end else begin
            seg7_d = seg_decode(disp_digit_q[scan_idx_q]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescaler_q <= '0;
            scan_idx_q  <= '0;
            select_q    <= ~NUM_DIGITS'(1);
            seg7_q      <= SEG_ZERO;
        end else begin
            prescaler_q <= prescaler_d;
            scan_idx_q  <= scan_idx_d;
            select_q    <= select_d;
            seg7_q      <= seg7_d;
        end
    end

`ifdef SEG7_DP_EN
    logic [NUM_DIGITS-1:0] dp_pend_q, dp_pend_d;
    logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
    logic                  dp_q, dp_d;

    always_comb begin
        dp_pend_d = capture ? dp_in : dp_pend_q;
        disp_dp_d = commit ? dp_pend_q : disp_dp_q;
        dp_d      = disp_ovf_q ? 1'b1 : ~disp_dp_q[scan_idx_q];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dp_pend_q <= '0;
            disp_dp_q <= '0;
            dp_q      <= 1'b1;
        end else begin
            dp_pend_q <= dp_pend_d;
            disp_dp_q <= disp_dp_d;
            dp_q      <= dp_d;
        end
    end

    assign dp = dp_q;
`endif

    assign seg7     = seg7_q;
    assign select   = select_q;
    assign overflow = disp_ovf_q;

endmodule

// File: tb/tb_seg7_mux_display.sv
// Scoreboard bench for seg7_mux_display: stimulus queues expected displays computed arithmetically,
// a negedge monitor pops them on each commit and checks the scanned digits every cycle.
module tb_seg7_mux_display;

    localparam int ND       = 4;
    localparam int DW       = 14;
    localparam int RD       = 2;
    localparam int BUSY_CYC = DW + 1;

    localparam logic [6:0] SEG_LUT [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    typedef struct packed {
        logic                 ovf;
        logic [ND-1:0]        dpm;
        logic [ND-1:0][6:0]   segs;
    } disp_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          load;
    logic [DW-1:0] value;
    logic          busy;
    logic          overflow;
    logic [6:0]    seg7;
    logic [ND-1:0] select;
`ifdef SEG7_DP_EN
    logic [ND-1:0] dp_in;
    logic          dp;
`endif

    always #5 clk = ~clk;

    seg7_mux_display #(
        .NUM_DIGITS (ND),
        .DATA_WIDTH (DW),
        .REFRESH_DIV(RD)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .value   (value),
        .load    (load),
        .busy    (busy),
        .overflow(overflow),
        .seg7    (seg7),
        .select  (select)
`ifdef SEG7_DP_EN
        ,
        .dp_in   (dp_in),
        .dp      (dp)
`endif
    );

    disp_t         exp_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    bit            exp_busy = 1'b0;
    int            busy_left = 0;
    bit            pending = 1'b0;
    logic [ND-1:0] dp_next = '0;

    // Expected display from decimal arithmetic: digit i = (v / 10^i) % 10, blanked above the top digit.
    function automatic disp_t model_disp(input int unsigned v, input logic [ND-1:0] dpm);
        disp_t       r;
        int unsigned pw = 1;
        r.ovf = (v >= 10 ** ND);
        r.dpm = dpm;
        for (int i = 0; i < ND; i++) begin
            if (r.ovf)                 r.segs[i] = 7'b0111111;
            else if (i == 0 || v >= pw) r.segs[i] = SEG_LUT[(v / pw) % 10];
            else                       r.segs[i] = 7'b1111111;
            pw = pw * 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        int            t;
        int            idx;
        bit            prev_busy;
        disp_t         disp_cur;
        disp_t         disp_prev;
        logic [ND-1:0] sel_exp;
        t         = 0;
        prev_busy = 1'b0;
        disp_cur  = model_disp(0, '0);
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                t         = 0;
                prev_busy = 1'b0;
                disp_cur  = model_disp(0, '0);
                chk("reset_busy", 32'(busy), 32'd0);
                chk("reset_overflow", 32'(overflow), 32'd0);
                chk("reset_select", 32'(select), 32'(4'b1110));
                chk("reset_seg7", 32'(seg7), 32'(7'b1000000));
`ifdef SEG7_DP_EN
                chk("reset_dp", 32'(dp), 32'd1);
`endif
            end else begin
                t++;
                disp_prev = disp_cur;
                if (prev_busy && !busy) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL commit: got a commit, expected none queued (t=%0t)", $time);
                    end else begin
                        disp_cur = exp_q.pop_front();
                        $display("commit: ovf=%0b segs=%h", disp_cur.ovf, disp_cur.segs);
                    end
                end
                chk("busy", 32'(busy), 32'(exp_busy));
                chk("overflow", 32'(overflow), 32'(disp_cur.ovf));
                idx     = ((t - 1) / RD) % ND;
                sel_exp = ~(ND'(1) << idx);
                chk("select", 32'(select), 32'(sel_exp));
                chk("seg7", 32'(seg7), 32'(disp_prev.segs[idx]));
`ifdef SEG7_DP_EN
                chk("dp", 32'(dp), disp_prev.ovf ? 32'd1 : 32'(~disp_prev.dpm[idx]));
`endif
                prev_busy = busy;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit ld, input logic [DW-1:0] v);
        @(posedge clk);
        #1;
        if (pending) begin
            busy_left = BUSY_CYC;
            pending   = 1'b0;
        end
        exp_busy = (busy_left != 0);
        if (busy_left > 0) busy_left--;
        load  = ld;
        value = v;
`ifdef SEG7_DP_EN
        dp_in = dp_next;
`endif
        if (ld) begin
            if (!exp_busy) begin
                pending = 1'b1;
                exp_q.push_back(model_disp(int'(v), dp_next));
                $display("load %0d accepted", v);
            end else begin
                $display("load %0d ignored while busy", v);
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_n   = 1'b0;
        load      = 1'b0;
        exp_q.delete();
        busy_left = 0;
        pending   = 1'b0;
        exp_busy  = 1'b0;
        $display("reset asserted");
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin : stimulus
        int unsigned dir_vals [9] = '{210, 10000, 7, 9999, 0, 16383, 1000, 9, 1234};
        reset_n = 1'b0;
        load    = 1'b0;
        value   = '0;
`ifdef SEG7_DP_EN
        dp_in   = '0;
`endif
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;

        foreach (dir_vals[i]) begin
            dp_next = (dir_vals[i] == 1234) ? 4'b0010 : '0;
            step(1'b1, DW'(dir_vals[i]));
            repeat (30) step(1'b0, '0);
        end

        // load pulsed during a conversion must be dropped
        step(1'b1, DW'(9999));
        step(1'b0, '0);
        step(1'b0, '0);
        step(1'b1, DW'(42));
        repeat (30) step(1'b0, '0);

        // reset in the middle of a conversion
        step(1'b1, DW'(5555));
        repeat (5) step(1'b0, '0);
        do_reset();
        repeat (20) step(1'b0, '0);

        // load held high: accepted exactly when the converter returns to idle
        for (int i = 0; i < 60; i++) begin
            dp_next = ND'($urandom);
            step(1'b1, DW'($urandom_range(0, 16383)));
        end

        for (int i = 0; i < 2000; i++) begin
            dp_next = ND'($urandom);
            if ($urandom_range(0, 3) == 0) step($urandom_range(0, 7) == 0, DW'($urandom_range(0, 99)));
            else                           step($urandom_range(0, 7) == 0, DW'($urandom_range(0, 16383)));
        end

        repeat (40) step(1'b0, '0);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
